uart_rx: RTL and testbench

- Serial receive stage that pairs with the console transmitter, completing the console UART.
- Oversamples the asynchronous `rx` line and deserialises 8N1 frames, LSB first.
- Pushes each good byte into an internal first-word-fall-through FIFO.
- The console's Wishbone side pops bytes from that FIFO and reads the error flags.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_rx_fifo.sv | 56 +++++
 rtl/uart_rx.sv | 135 +++++++++++++
 tb/tb_uart_rx.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and baud divider helper.
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    STOP
  } uart_rx_state_t;

  // Whole clocks per bit period; the fraction is dropped and absorbed by mid-bit sampling.
  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO: the head entry is always presented on dout while not empty.
module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  localparam logic [CW-1:0] ONE  = CW'(1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_pop;
  logic             do_push;

  assign empty   = (count == '0);
  assign full    = (count == FULL);
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a full FIFO needs for the incoming word.
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + ONE;
        2'b01:   count <= count - ONE;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; count/pointers already mark every entry invalid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises rx, samples mid-bit, and queues good bytes in a FWFT FIFO.
module uart_rx
  import uart_pkg::*;
#(
  parameter int FREQUENCY    = 25000000,
  parameter int BAUD_RATE    = 115200,
  parameter int CLKS_PER_BIT = clks_per_bit(FREQUENCY, BAUD_RATE),
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rx,
  output logic [UART_DATA_BITS-1:0]   dout,
  output logic                        valid,
  input  logic                        rd,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        full,
  output logic                        overrun,
  output logic                        frame_err,
  input  logic                        clr_err
);

  localparam logic [31:0] HALF_BIT  = 32'(CLKS_PER_BIT / 2);
  localparam logic [31:0] LAST_TICK = 32'(CLKS_PER_BIT - 1);

  uart_rx_state_t            state, state_n;
  logic [31:0]               div, div_n;
  logic [2:0]                bit_cnt, bit_cnt_n;
  logic [UART_DATA_BITS-1:0] sh, sh_n;
  logic                      rx_meta, rxs, rxs_prev;
  logic                      push_q, push_n;
  logic                      frame_set;
  logic                      overrun_set;
  logic                      empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_meta   <= 1'b1;
      rxs       <= 1'b1;
      rxs_prev  <= 1'b1;
      state     <= IDLE;
      div       <= '0;
      bit_cnt   <= '0;
      sh        <= '0;
      push_q    <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_meta   <= rx;
      rxs       <= rx_meta;
      rxs_prev  <= rxs;
      state     <= state_n;
      div       <= div_n;
      bit_cnt   <= bit_cnt_n;
      sh        <= sh_n;
      push_q    <= push_n;
      // A new error in the same cycle as clr_err wins over the clear.
      overrun   <= overrun_set | (overrun & ~clr_err);
      frame_err <= frame_set | (frame_err & ~clr_err);
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_n   = state;
    div_n     = div;
    bit_cnt_n = bit_cnt;
    sh_n      = sh;
    push_n    = 1'b0;
    frame_set = 1'b0;
    unique case (state)
      WAIT_HIGH: if (rxs) state_n = IDLE;
      IDLE: begin
        if (rxs_prev && !rxs) begin
          div_n   = '0;
          state_n = START;
        end
      end
      START: begin
        if (div == HALF_BIT) begin
          div_n     = '0;
          bit_cnt_n = '0;
          state_n   = rxs ? IDLE : DATA;
        end else begin
          div_n = div + 32'd1;
        end
      end
      DATA: begin
        if (div == LAST_TICK) begin
          div_n     = '0;
          sh_n      = {rxs, sh[UART_DATA_BITS-1:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = STOP;
        end else begin
          div_n = div + 32'd1;
        end
      end
      STOP: begin
        if (div == LAST_TICK) begin
          div_n = '0;
          if (rxs) begin
            push_n  = 1'b1;
            state_n = IDLE;
          end else begin
            frame_set = 1'b1;
            state_n   = WAIT_HIGH;
          end
        end else begin
          div_n = div + 32'd1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // sh is stable for the push cycle: the next frame cannot shift within one clock.
  assign overrun_set = push_q && full && !rd;
  assign valid       = !empty;

  uart_rx_fifo #(
    .WIDTH(UART_DATA_BITS),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push_q),
    .din  (sh),
    .pop  (rd),
    .dout (dout),
    .count(count),
    .full (full),
    .empty(empty)
  );

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: serial frames in, FIFO contents and flags checked against a queue model.
module tb_uart_rx;

  localparam int CPB   = 217;
  localparam int DEPTH = 16;
  // Edges after the start-bit drive: 2 sync flops + 1 to see the fall, half a bit, then 9 bit periods.
  localparam int STOP_SAMPLE = 3 + CPB / 2 + 1 + 9 * CPB;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic       rd;
  logic       clr_err;
  logic [7:0] dout;
  logic       valid;
  logic [4:0] count;
  logic       full;
  logic       overrun;
  logic       frame_err;

  int         checks   = 0;
  int         failures = 0;
  logic [7:0] model_q[$];
  bit         exp_overrun;
  bit         exp_frame;
  int         rise_at;
  logic [7:0] popped;

  always #5 clk = ~clk;

  uart_rx #(
    .FREQUENCY   (25000000),
    .BAUD_RATE   (115200),
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .rx       (rx),
    .dout     (dout),
    .valid    (valid),
    .rd       (rd),
    .count    (count),
    .full     (full),
    .overrun  (overrun),
    .frame_err(frame_err),
    .clr_err  (clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    int n;
    n = model_q.size();
    check({tag, ".count"}, 32'(count), 32'(n));
    check({tag, ".valid"}, 32'(valid), 32'(n > 0));
    check({tag, ".full"}, 32'(full), 32'(n == DEPTH));
    check({tag, ".dout"}, 32'(dout), (n > 0) ? 32'(model_q[0]) : 32'h0);
    check({tag, ".overrun"}, 32'(overrun), 32'(exp_overrun));
    check({tag, ".frame_err"}, 32'(frame_err), 32'(exp_frame));
  endtask

  // Drives one 10-bit frame; optionally pulses rd so it lands on the cycle the byte is pushed.
  task automatic send_frame(input logic [7:0] data, input bit stop_bit, input bit rd_on_push,
                            output int rise, output logic [7:0] head);
    bit was_valid;
    int pos;
    was_valid = valid;
    rise      = -1;
    head      = 8'h00;
    @(posedge clk);
    #1 rx = 1'b0;
    for (int c = 1; c <= 10 * CPB; c++) begin
      tick();
      if (!was_valid && valid && rise < 0) rise = c;
      pos = c / CPB;
      if (pos == 0)      rx = 1'b0;
      else if (pos <= 8) rx = data[pos-1];
      else               rx = stop_bit;
      if (c == STOP_SAMPLE) head = dout;
      rd = rd_on_push && (c == STOP_SAMPLE);
    end
    rd = 1'b0;
  endtask

  // Reference behaviour of one complete frame at the queue level.
  task automatic model_frame(input logic [7:0] data, input bit stop_bit, input bit rd_on_push,
                             input logic [7:0] head);
    if (!stop_bit) begin
      exp_frame = 1'b1;
    end else begin
      if (rd_on_push && model_q.size() > 0) begin
        check("rd_on_push.head", 32'(head), 32'(model_q[0]));
        void'(model_q.pop_front());
      end
      if (model_q.size() < DEPTH) model_q.push_back(data);
      else                        exp_overrun = 1'b1;
    end
  endtask

  task automatic frame(input logic [7:0] data, input bit stop_bit, input bit rd_on_push);
    send_frame(data, stop_bit, rd_on_push, rise_at, popped);
    model_frame(data, stop_bit, rd_on_push, popped);
  endtask

  task automatic pop_one(input string tag);
    check({tag, ".head"}, 32'(dout), (model_q.size() > 0) ? 32'(model_q[0]) : 32'h0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    if (model_q.size() > 0) void'(model_q.pop_front());
    check_state(tag);
  endtask

  task automatic clear_errors();
    clr_err = 1'b1;
    tick();
    clr_err     = 1'b0;
    exp_overrun = 1'b0;
    exp_frame   = 1'b0;
  endtask

  initial begin
    logic [7:0] b;
    int         n;
    rst         = 1'b0;
    rx          = 1'b1;
    rd          = 1'b0;
    clr_err     = 1'b0;
    exp_overrun = 1'b0;
    exp_frame   = 1'b0;
    repeat (4) tick();
    check_state("reset");
    rst = 1'b1;
    repeat (10) tick();

    // Single byte, with exact valid timing relative to the stop-bit sample.
    frame(8'h55, 1'b1, 1'b0);
    check("t1.valid_rise", 32'(rise_at), 32'(STOP_SAMPLE + 1));
    check_state("t1");

    // Back-to-back bytes behind the first, then drain.
    frame(8'hA3, 1'b1, 1'b0);
    frame(8'h0F, 1'b1, 1'b0);
    check_state("t2.queued");
    pop_one("t2.pop0");
    pop_one("t2.pop1");
    pop_one("t2.pop2");

    // rd on an empty FIFO must not underflow.
    pop_one("t2.pop_empty");

    // Short low glitch is a false start.
    rx = 1'b0;
    repeat (50) tick();
    rx = 1'b1;
    repeat (3 * CPB) tick();
    check_state("t3.glitch");

    // Framing error followed by a long break must not retrigger.
    frame(8'h41, 1'b0, 1'b0);
    repeat (3000) tick();
    check_state("t4.break");
    rx = 1'b1;
    repeat (20) tick();
    frame(8'h42, 1'b1, 1'b0);
    check_state("t4.after");
    clear_errors();
    check_state("t4.clr");
    pop_one("t4.pop");

    // Randomised bytes with random draining.
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom);
      frame(b, 1'b1, 1'($urandom_range(0, 1)));
      check_state("rand.rx");
      n = $urandom_range(0, model_q.size());
      for (int k = 0; k < n; k++) pop_one("rand.pop");
    end
    while (model_q.size() > 0) pop_one("rand.drain");

    // Fill to full, overflow one byte, then push into a full FIFO with a same-cycle pop.
    for (int i = 0; i <= 16; i++) begin
      frame(8'(i), 1'b1, 1'b0);
      if (i == 15) check_state("t5.full");
    end
    check_state("t5.overrun");
    clear_errors();
    check_state("t5.clr");
    frame(8'h7E, 1'b1, 1'b1);
    check_state("t6.push_pop_full");
    for (int i = 0; i < DEPTH; i++) pop_one("t6.drain");

    // Reset in the middle of a frame discards everything, including the partial byte.
    frame(8'h33, 1'b1, 1'b0);
    check_state("t6.one");
    @(posedge clk);
    #1 rx = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      tick();
      rx = (c / CPB == 0) ? 1'b0 : (c / CPB) % 2 == 1;
    end
    rst = 1'b0;
    tick();
    tick();
    rx  = 1'b1;
    rst = 1'b1;
    model_q.delete();
    exp_overrun = 1'b0;
    exp_frame   = 1'b0;
    check_state("t6.reset");
    repeat (2500) tick();
    check_state("t6.no_partial");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
